// File: rtl/bf16_pkg.sv
// bf16_pkg: shared bf16 constants, accumulator FSM encoding and a leading-zero helper.
package bf16_pkg;
    localparam int BF16_W = 16;
    localparam logic [BF16_W-1:0] BF16_ZERO = 16'h0000;
    localparam logic [BF16_W-1:0] BF16_QNAN = 16'h7FC0;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

    function automatic logic [3:0] lzc11(input logic [10:0] v);
        lzc11 = 4'd11;
        for (int i = 0; i < 11; i++)
            if (v[i]) lzc11 = 4'(10 - i);
    endfunction
endpackage

// File: rtl/adder_bf16.sv
// adder_bf16: combinational bf16 adder, round-to-nearest-even, gradual underflow.
module adder_bf16
    import bf16_pkg::*;
(
    input  logic [BF16_W-1:0] a_i,
    input  logic [BF16_W-1:0] b_i,
    output logic [BF16_W-1:0] sum_o
);
    logic [BF16_W-1:0] big, sml;
    logic [7:0]  eb, es, d, mb, ms;
    logic [10:0] al, sh, as;
    logic [11:0] s;
    logic [10:0] n;
    logic [9:0]  e, ef, emax, lz, sh2;
    logic [8:0]  mr;
    logic        st, st2, sub, up, nan_in, inf_in;
    always_comb begin
        big    = (b_i[14:0] > a_i[14:0]) ? b_i : a_i;
        sml    = (b_i[14:0] > a_i[14:0]) ? a_i : b_i;
        eb     = (big[14:7] == 8'd0) ? 8'd1 : big[14:7];
        es     = (sml[14:7] == 8'd0) ? 8'd1 : sml[14:7];
        mb     = {|big[14:7], big[6:0]};
        ms     = {|sml[14:7], sml[6:0]};
        d      = eb - es;
        al     = {mb, 3'b000};
        sh     = {ms, 3'b000};
        as     = (d >= 8'd11) ? 11'd0 : sh >> d;
        st     = (d >= 8'd11) ? |ms : |(sh & ~({11{1'b1}} << d));
        sub    = big[15] ^ sml[15];
        // subtracting the sticky bit as a borrow keeps the remainder positive
        s      = sub ? {1'b0, al} - {1'b0, as} - {11'd0, st} : {1'b0, al} + {1'b0, as};
        emax   = {2'b00, eb} - 10'd1;
        lz     = {6'd0, lzc11(s[10:0])};
        sh2    = (lz < emax) ? lz : emax;
        n      = s[11] ? s[11:1] : s[10:0] << sh2;
        st2    = s[11] ? (st | s[0]) : st;
        e      = s[11] ? {2'b00, eb} + 10'd1 : {2'b00, eb} - sh2;
        up     = n[2] & (n[3] | n[1] | n[0] | st2);
        mr     = {1'b0, n[10:3]} + {8'd0, up};
        ef     = mr[8] ? e + 10'd1 : (mr[7] ? e : 10'd0);
        nan_in = (&a_i[14:7] && |a_i[6:0]) || (&b_i[14:7] && |b_i[6:0]);
        inf_in = (&a_i[14:7] && ~|a_i[6:0]) || (&b_i[14:7] && ~|b_i[6:0]);
        if (nan_in || (inf_in && &sml[14:7] && sub))
            sum_o = BF16_QNAN;
        else if (inf_in)
            sum_o = big;
        else if (s == 12'd0 && !st)
            sum_o = {big[15] & sml[15], 15'd0};
        else if (ef >= 10'd255)
            sum_o = {big[15], 8'hFF, 7'd0};
        else
            sum_o = {big[15], ef[7:0], mr[8] ? 7'd0 : mr[6:0]};
    end
endmodule

// File: rtl/bf16_mac_accumulator.sv
// bf16_mac_accumulator: sums variable-length runs of bf16 partial dot products
// into one result on a valid/ready output with zero-bubble turnaround.
module bf16_mac_accumulator
    import bf16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BF16_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BF16_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_beats,
    output logic              out_sat,
    input  logic              out_ready,
    output logic              busy
);
    state_e            state_q, state_d;
    logic [BF16_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d, accept, load, add;

    adder_bf16 u_add (.a_i(acc_q), .b_i(in_data), .sum_o(sum));

    always_comb begin
        in_ready = (state_q == HOLD) ? out_ready : 1'b1;
        accept   = in_valid && in_ready;
        // first beat is loaded, never added to zero, so -0 and NaN payloads survive
        load     = accept && state_q != ACC;
        add      = accept && state_q == ACC;
        state_d  = accept ? (in_last ? HOLD : ACC)
                 : (state_q == HOLD && out_ready) ? IDLE : state_q;
        acc_d    = load ? in_data : add ? sum : acc_q;
        cnt_d    = load ? CNT_W'(1) : (add && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        sat_d    = load ? 1'b0 : (add && &cnt_q) ? 1'b1 : sat_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= BF16_ZERO;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign out_valid = state_q == HOLD;
    assign busy      = state_q == ACC;
    assign out_data  = acc_q;
    assign out_beats = cnt_q;
    assign out_sat   = sat_q;
endmodule

// File: tb/tb_bf16_mac_accumulator.sv
// tb_bf16_mac_accumulator: directed and randomized checks against a real-arithmetic bf16 model.
module tb_bf16_mac_accumulator;
    localparam int CW = 2;
    logic          clk = 1'b0, reset = 1'b1;
    logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [15:0]   in_data = 16'h0000;
    logic          in_ready, out_valid, out_sat, busy;
    logic [15:0]   out_data;
    logic [CW-1:0] out_beats;
    int            total = 0, bad = 0;

    bf16_mac_accumulator #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_beats(out_beats), .out_sat(out_sat),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic r);
        in_valid = v; in_data = d; in_last = l; out_ready = r;
        @(posedge clk); #1;
    endtask

    function automatic real b2r(input logic [15:0] b);
        logic [10:0] de;
        if (b[14:0] == 15'd0) return $bitstoreal({b[15], 63'd0});
        de = 11'(int'(b[14:7]) - 127 + 1023);
        return $bitstoreal({b[15], de, b[6:0], 45'd0});
    endfunction

    function automatic logic [15:0] r2b(input real x);
        logic [63:0] d;
        logic [8:0]  mr;
        logic        up;
        int          e;
        d = $realtobits(x);
        if (d[62:52] == 11'd0) return {d[63], 15'd0};
        e  = int'(d[62:52]) - 1023 + 127;
        up = d[44] & ((|d[43:0]) | d[45]);
        mr = {2'b01, d[51:45]} + {8'd0, up};
        if (mr[8]) begin e++; mr = mr >> 1; end
        return {d[63], 8'(e), mr[6:0]};
    endfunction

    function automatic logic [15:0] rnd_bf16();
        return {1'($urandom), 8'($urandom_range(124, 131)), 7'($urandom)};
    endfunction

    function automatic logic [15:0] pad(input logic [CW-1:0] c);
        return {{(16-CW){1'b0}}, c};
    endfunction

    initial begin
        logic [15:0] ea, x, held;
        int          n, w;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_beats", pad(out_beats), 16'd0);
        chk("rst_out_sat", {15'd0, out_sat}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        reset = 1'b0;
        // reset mid-run discards the partial sum
        drive(1, 16'h3F80, 0, 0);
        drive(1, 16'h4000, 0, 0);
        chk("midrun_busy", {15'd0, busy}, 16'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", {15'd0, busy}, 16'd0);
        chk("async_rst_data", out_data, 16'h0000);
        @(posedge clk); #1 reset = 1'b0;
        drive(1, 16'h3F80, 1, 0);
        chk("post_rst_valid", {15'd0, out_valid}, 16'd1);
        chk("post_rst_data", out_data, 16'h3F80);
        chk("post_rst_beats", pad(out_beats), 16'd1);
        drive(0, 16'h0000, 0, 1);
        chk("post_rst_consumed", {15'd0, out_valid}, 16'd0);
        // three-beat run
        drive(1, 16'h3F80, 0, 1);
        drive(1, 16'h4000, 0, 1);
        chk("three_no_valid", {15'd0, out_valid}, 16'd0);
        drive(1, 16'h4040, 1, 1);
        chk("three_valid", {15'd0, out_valid}, 16'd1);
        chk("three_data", out_data, 16'h40C0);
        chk("three_beats", pad(out_beats), 16'd3);
        drive(0, 16'h0000, 0, 1);
        // single beat with last
        drive(1, 16'hBF00, 1, 1);
        chk("single_valid", {15'd0, out_valid}, 16'd1);
        chk("single_data", out_data, 16'hBF00);
        chk("single_beats", pad(out_beats), 16'd1);
        drive(0, 16'h0000, 0, 1);
        // backpressure in HOLD
        drive(1, 16'h3F80, 1, 0);
        in_valid = 1'b1; in_data = 16'h4000; in_last = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
            chk("bp_data_stable", out_data, 16'h3F80);
            chk("bp_valid", {15'd0, out_valid}, 16'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1; #1;
        chk("bp_release_ready", {15'd0, in_ready}, 16'd1);
        drive(1, 16'h4000, 1, 1);
        chk("bp_held_valid", {15'd0, out_valid}, 16'd1);
        chk("bp_held_data", out_data, 16'h4000);
        chk("bp_held_beats", pad(out_beats), 16'd1);
        drive(0, 16'h0000, 0, 1);
        // zero-bubble turnaround
        drive(1, 16'h3F80, 0, 1);
        drive(1, 16'h3F80, 1, 1);
        chk("zb_first_valid", {15'd0, out_valid}, 16'd1);
        chk("zb_first_data", out_data, 16'h4000);
        chk("zb_first_beats", pad(out_beats), 16'd2);
        drive(1, 16'h4000, 1, 1);
        chk("zb_second_valid", {15'd0, out_valid}, 16'd1);
        chk("zb_second_data", out_data, 16'h4000);
        chk("zb_second_beats", pad(out_beats), 16'd1);
        drive(0, 16'h0000, 0, 1);
        chk("zb_idle", {15'd0, out_valid}, 16'd0);
        // saturation
        for (int i = 0; i < 5; i++) drive(1, 16'h0000, i == 4, 0);
        chk("sat_beats", pad(out_beats), 16'd3);
        chk("sat_flag", {15'd0, out_sat}, 16'd1);
        chk("sat_data", out_data, 16'h0000);
        drive(1, 16'h3F80, 1, 1);
        chk("sat_cleared", {15'd0, out_sat}, 16'd0);
        chk("sat_next_beats", pad(out_beats), 16'd1);
        drive(0, 16'h0000, 0, 1);
        // randomized runs against the real-arithmetic model
        ea = 16'h0000;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                x  = rnd_bf16();
                ea = (k == 0) ? x : r2b(b2r(ea) + b2r(x));
                if ($urandom_range(0, 3) == 0) drive(0, 16'hDEAD, 1, 0);
                chk("rnd_in_ready", {15'd0, in_ready}, 16'd1);
                drive(1, x, k == n - 1, 0);
                if (k < n - 1) chk("rnd_busy", {15'd0, busy}, 16'd1);
            end
            chk("rnd_valid", {15'd0, out_valid}, 16'd1);
            chk("rnd_data", out_data, ea);
            chk("rnd_beats", pad(out_beats), 16'(n > 3 ? 3 : n));
            chk("rnd_sat", {15'd0, out_sat}, {15'd0, n > 3});
            held = ea;
            w = $urandom_range(0, 2);
            for (int i = 0; i < w; i++) begin
                drive(1, 16'h1234, 1, 0);
                chk("rnd_hold_data", out_data, held);
            end
            drive(0, 16'h0000, 0, 1);
            chk("rnd_consumed", {15'd0, out_valid}, 16'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
